// File: rtl/shift_sub_divider.sv
// ---------------------------------------------------------------------------
// shift_sub_divider
//   Multi-cycle unsigned restoring (shift-and-subtract) divider. Produces one
//   quotient bit per clock, so a division takes WIDTH cycles from the accept
//   edge to the result. No hard divider or DSP resources are used.
//
//   Handshake: a request is accepted on a rising edge where start=1 and the
//   unit is idle (ready=1). The result is presented with a one-cycle out_valid
//   pulse. quotient/remainder/div_by_zero hold their values until the next
//   result. A zero divisor is answered on the accept edge itself with
//   quotient=all-ones, remainder=dividend and div_by_zero=1.
//
// Parameters
//   WIDTH        operand/result width in bits (>= 2)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request, accepted only while ready=1
//   dividend     unsigned dividend, sampled on the accept edge
//   divisor      unsigned divisor, sampled on the accept edge
//   ready        1 while idle; a new start is accepted
//   out_valid    one-cycle pulse marking a new result
//   quotient     floor(dividend / divisor), held until the next result
//   remainder    dividend mod divisor, held until the next result
//   div_by_zero  1 when the last result had divisor == 0
// ---------------------------------------------------------------------------
module shift_sub_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  state_e state_q, state_d;

  // Working registers: dq shifts the dividend out of its MSB while quotient
  // bits shift in at the LSB. The partial remainder is always < divisor, so
  // it is stored in WIDTH bits; the compare/subtract below is WIDTH+1 bits.
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] quotient_d;
  logic [WIDTH-1:0] remainder_d;
  logic             div_by_zero_d;
  logic             out_valid_d;

  // One restoring iteration.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   dv_ext;
  logic             qbit;
  logic [WIDTH-1:0] pr_next;
  logic [WIDTH-1:0] dq_next;

  always_comb begin
    trial   = {pr_q, dq_q[WIDTH-1]};
    dv_ext  = {1'b0, dv_q};
    qbit    = (trial >= dv_ext);
    pr_next = WIDTH'(qbit ? (trial - dv_ext) : trial);
    dq_next = {dq_q[WIDTH-2:0], qbit};
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dq_q        <= '0;
      dv_q        <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dq_q        <= dq_d;
      dv_q        <= dv_d;
      pr_q        <= pr_d;
      cnt_q       <= cnt_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= div_by_zero_d;
      out_valid   <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    dq_d          = dq_q;
    dv_d          = dv_q;
    pr_d          = pr_q;
    cnt_d         = cnt_q;
    quotient_d    = quotient;
    remainder_d   = remainder;
    div_by_zero_d = div_by_zero;
    out_valid_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dq_d  = dividend;
          dv_d  = divisor;
          pr_d  = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            // Answered immediately; the unit never leaves idle.
            quotient_d    = '1;
            remainder_d   = dividend;
            div_by_zero_d = 1'b1;
            out_valid_d   = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        // start is ignored here; operands were captured on the accept edge.
        pr_d  = pr_next;
        dq_d  = dq_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          quotient_d    = dq_next;
          remainder_d   = pr_next;
          div_by_zero_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    ready = (state_q == StIdle);
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
module tb_shift_sub_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_res = 0;

  // Scoreboard: each out_valid must match the oldest outstanding request,
  // including the cycle it was due on.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_vec++;
      n_res++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out_valid: got q=%h r=%h dbz=%b cyc=%0d, required no result",
                 quotient, remainder, div_by_zero, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz || cyc != e.due) begin
          n_err++;
          $display("FAIL result#%0d: got q=%h r=%h dbz=%b cyc=%0d, required q=%h r=%h dbz=%b cyc=%0d",
                   n_res, quotient, remainder, div_by_zero, cyc, e.q, e.r, e.dbz, e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Called just after a negedge; returns just after a negedge with ready=1.
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, required ready=1", n);
    end
  endtask

  // Drive one request; start is left as-is on return (caller decides).
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
    exp_t e;
    wait_ready();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.due = cyc + 1 + (dbz ? 0 : W);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
    drive(a, b, q, r, dbz);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{a: 16'd100,   b: 16'd7,      q: 16'd14,   r: 16'd2, dbz: 1'b0};
    vecs[1] = '{a: 16'hFFFF,  b: 16'd1,      q: 16'hFFFF, r: 16'd0, dbz: 1'b0};
    vecs[2] = '{a: 16'hFFFF,  b: 16'hFFFF,   q: 16'd1,    r: 16'd0, dbz: 1'b0};
    vecs[3] = '{a: 16'd3,     b: 16'd10,     q: 16'd0,    r: 16'd3, dbz: 1'b0};
    vecs[4] = '{a: 16'd5,     b: 16'd0,      q: 16'hFFFF, r: 16'd5, dbz: 1'b1};
    vecs[5] = '{a: 16'd9,     b: 16'd3,      q: 16'd3,    r: 16'd0, dbz: 1'b0};
    vecs[6] = '{a: 16'd0,     b: 16'd5,      q: 16'd0,    r: 16'd0, dbz: 1'b0};
    vecs[7] = '{a: 16'd0,     b: 16'd0,      q: 16'hFFFF, r: 16'd0, dbz: 1'b1};
    vecs[8] = '{a: 16'd40000, b: 16'd123,    q: 16'd325,  r: 16'd25, dbz: 1'b0};
    vecs[9] = '{a: 16'h8000,  b: 16'h8001,   q: 16'd0,    r: 16'h8000, dbz: 1'b0};

    // Reset state.
    #1 rst = 1'b1;
    #2;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
    end
    drain();

    // Results hold after out_valid drops.
    repeat (3) @(negedge clk);
    chk("hold_quotient", 32'(quotient), 32'h0);
    chk("hold_remainder", 32'(remainder), 32'h8000);

    // start while busy is ignored.
    issue(16'd1000, 16'd9, 16'd111, 16'd1, 1'b0);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd7;
    divisor  = 16'd2;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (2) @(negedge clk);

    // Reset during a division discards it.
    issue(16'd500, 16'd3, 16'd166, 16'd2, 1'b0);
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(16'd500, 16'd3, 16'd166, 16'd2, 1'b0);
    drain();

    // Back-to-back with start held high; operands scrambled while busy.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b, q, r;
      logic         z;
      a = W'($urandom);
      b = (i % 4 == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
      if (i % 97 == 5) b = '0;
      if (b == '0) begin
        q = '1;
        r = a;
        z = 1'b1;
      end else begin
        q = a / b;
        r = a % b;
        z = 1'b0;
      end
      drive(a, b, q, r, z);
      if (!ready) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
    end
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
